// File: rtl/alu_iter_exec_pkg.sv
// rtl/alu_iter_exec_pkg.sv - ALU select codes, shift-amount width and FSM encodings for alu_iter_exec
package alu_iter_exec_pkg;

    localparam int SHAMT_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    function automatic logic is_shift(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// rtl/alu_iter_shifter.sv - one-bit-per-step shifter with down-counter; combinational
// barrel shift when ALU_BARREL_SHIFT_EN is defined
module alu_iter_shifter
    import alu_iter_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [3:0]         sel,
    input  logic [XLEN-1:0]    a,
    input  logic [SHAMT_W-1:0] amt,
    output logic [XLEN-1:0]    value,
    output logic               zero
);

`ifdef ALU_BARREL_SHIFT_EN
    // Whole shift resolves in the cycle after acceptance, so the count is always spent.
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, load, step};
    assign zero      = 1'b1;

    always_comb begin
        value = a;
        case (sel)
            ALU_SLL: value = a << amt;
            ALU_SRL: value = a >> amt;
            ALU_SRA: value = $signed(a) >>> amt;
            default: value = a;
        endcase
    end
`else
    logic [XLEN-1:0]    sh;
    logic [SHAMT_W-1:0] cnt;
    logic [3:0]         mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            cnt  <= '0;
            mode <= ALU_SLL;
        end else if (load) begin
            sh   <= a;
            cnt  <= amt;
            mode <= sel;
        end else if (step) begin
            case (mode)
                ALU_SLL: sh <= {sh[XLEN-2:0], 1'b0};
                ALU_SRL: sh <= {1'b0, sh[XLEN-1:1]};
                default: sh <= {sh[XLEN-1], sh[XLEN-1:1]};
            endcase
            cnt <= cnt - 1'b1;
        end
    end

    assign value = sh;
    assign zero  = (cnt == '0);
`endif

endmodule

// File: rtl/alu_iter_exec.sv
// rtl/alu_iter_exec.sv - multi-cycle execute unit: FSM, one-cycle datapath, result/flag registers.
// ALU_BARREL_SHIFT_EN selects single-cycle shifts instead of the iterative shifter.
module alu_iter_exec
    import alu_iter_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zf,
    output logic            cf,
    output logic            vf,
    output logic            sf
);

    logic [0:0]      state;
    logic [3:0]      sel_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] sh_value;
    logic            sh_zero;
    logic            accept;
    logic            op_done;
    logic            sh_step;
    logic            sh_load;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] res_n;
    logic            cf_n;
    logic            vf_n;

    assign busy    = (state == ST_EXEC);
    assign accept  = start && !busy && !flush;
    assign sh_load = accept && is_shift(alu_sel);
    assign sh_step = busy && !flush && is_shift(sel_q) && !sh_zero;
    assign op_done = busy && !flush && (!is_shift(sel_q) || sh_zero);

    // The iterative shifter captures raw operands on the accepting edge; the barrel
    // variant works from the latched copies during the single execute cycle.
    alu_iter_shifter #(.XLEN(XLEN)) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sh_load),
        .step  (sh_step),
`ifdef ALU_BARREL_SHIFT_EN
        .sel   (sel_q),
        .a     (a_q),
        .amt   (b_q[SHAMT_W-1:0]),
`else
        .sel   (alu_sel),
        .a     (op_a),
        .amt   (op_b[SHAMT_W-1:0]),
`endif
        .value (sh_value),
        .zero  (sh_zero)
    );

    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        diff  = {1'b0, a_q} - {1'b0, b_q};
        res_n = '0;
        cf_n  = 1'b0;
        vf_n  = 1'b0;
        case (sel_q)
            ALU_ADD: begin
                res_n = sum[XLEN-1:0];
                cf_n  = sum[XLEN];
                vf_n  = (a_q[XLEN-1] == b_q[XLEN-1]) && (sum[XLEN-1] != a_q[XLEN-1]);
            end
            ALU_SUB: begin
                res_n = diff[XLEN-1:0];
                cf_n  = !diff[XLEN];
                vf_n  = (a_q[XLEN-1] != b_q[XLEN-1]) && (diff[XLEN-1] != a_q[XLEN-1]);
            end
            ALU_AND:  res_n = a_q & b_q;
            ALU_OR:   res_n = a_q | b_q;
            ALU_XOR:  res_n = a_q ^ b_q;
            ALU_SLT:  res_n = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            ALU_SLTU: res_n = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            ALU_PASS: res_n = b_q;
            ALU_SLL, ALU_SRL, ALU_SRA: res_n = sh_value;
            default:  res_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            done   <= 1'b0;
            result <= '0;
            zf     <= 1'b0;
            cf     <= 1'b0;
            vf     <= 1'b0;
            sf     <= 1'b0;
            sel_q  <= ALU_ADD;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else if (accept) begin
                state <= ST_EXEC;
                sel_q <= alu_sel;
                a_q   <= op_a;
                b_q   <= op_b;
            end else if (op_done) begin
                state  <= ST_IDLE;
                done   <= 1'b1;
                result <= res_n;
                zf     <= (res_n == '0);
                cf     <= cf_n;
                vf     <= vf_n;
                sf     <= res_n[XLEN-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_iter_exec.sv
// tb/tb_alu_iter_exec.sv - scoreboard bench for alu_iter_exec with a behavioural reference model
module tb_alu_iter_exec;
    import alu_iter_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  alu_sel = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, done, zf, cf, vf, sf;
    logic [31:0] result;

    alu_iter_exec #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result),
        .zf(zf), .cf(cf), .vf(vf), .sf(sf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        z, c, v, s;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          passed = 0;
    int          total = 0;
    int          dones = 0;
    logic [31:0] last_res = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, want);
    endtask

    function automatic exp_t model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, sr;
        int     amt;
        amt   = int'(b % 32);
        sa    = $signed(a);
        sb    = $signed(b);
        e.res = 32'd0;
        e.c   = 1'b0;
        e.v   = 1'b0;
        e.due = 0;
        case (s)
            ALU_ADD: begin
                e.res = a + b;
                e.c   = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                sr    = sa + sb;
                e.v   = (sr != longint'($signed(e.res)));
            end
            ALU_SUB: begin
                e.res = a - b;
                e.c   = (a >= b);
                sr    = sa - sb;
                e.v   = (sr != longint'($signed(e.res)));
            end
            ALU_AND:  e.res = a & b;
            ALU_OR:   e.res = a | b;
            ALU_XOR:  e.res = a ^ b;
            ALU_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  e.res = a << amt;
            ALU_SRL:  e.res = a >> amt;
            ALU_SRA:  e.res = 32'(sa >>> amt);
            ALU_PASS: e.res = b;
            default:  e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        e.s = e.res[31];
        return e;
    endfunction

    function automatic int latency(input logic [3:0] s, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return 1 + 0 * int'(s) + 0 * int'(b[0]);
`else
        if (s == ALU_SLL || s == ALU_SRL || s == ALU_SRA) return int'(b % 32) + 1;
        return 1;
`endif
    endfunction

    // Monitor: every done pops one expected response.
    exp_t m;
    always @(negedge clk) begin
        if (rst_n && done) begin
            dones++;
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 want no pending op (cycle %0d)", cyc);
            end else begin
                m = q.pop_front();
                chk("result", result, m.res);
                chk("zf", {31'd0, zf}, {31'd0, m.z});
                chk("cf", {31'd0, cf}, {31'd0, m.c});
                chk("vf", {31'd0, vf}, {31'd0, m.v});
                chk("sf", {31'd0, sf}, {31'd0, m.s});
                chk("done_cycle", cyc, m.due);
                last_res = m.res;
            end
        end
    end

    task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_done);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            $display("FAIL issue_timeout: got busy=1 want busy=0 within 100 cycles");
            return;
        end
        alu_sel = s;
        op_a    = a;
        op_b    = b;
        start   = 1'b1;
        if (expect_done) begin
            e     = model(s, a, b);
            e.due = cyc + 1 + latency(s, b);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        op_a    = $urandom;
        op_b    = $urandom;
        alu_sel = 4'($urandom_range(0, 15));
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    int d0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, zf, cf, vf, sf}, 32'd0);
        rst_n = 1'b1;

        issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
        issue(ALU_SUB, 32'd5, 32'd5, 1'b1);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1);

        // A start arriving mid-op must be ignored.
        issue(ALU_SRA, 32'h8000_0000, 32'd31, 1'b1);
        @(negedge clk);
        alu_sel = ALU_ADD;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        issue(ALU_SRL, 32'h0000_00F0, 32'h0000_0024, 1'b1);
        issue(ALU_SLL, 32'hDEAD_BEEF, 32'h0000_0020, 1'b1);
        issue(ALU_PASS, 32'd0, 32'h1234_5678, 1'b1);
        wait_idle();

        issue(ALU_SLL, 32'h0000_0003, 32'd10, 1'b0);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_result_held", result, last_res);
        d0 = dones;
        repeat (15) @(negedge clk);
        chk("flush_no_done", dones, d0);

        @(negedge clk);
        alu_sel = ALU_ADD;
        op_a    = 32'd1;
        op_b    = 32'd2;
        start   = 1'b1;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        d0 = dones;
        repeat (4) @(negedge clk);
        chk("flush_start_no_done", dones, d0);

        for (int i = 0; i < 40; i++) begin
            issue(4'($urandom_range(0, 15)), $urandom, $urandom, 1'b1);
        end
        wait_idle();

        issue(ALU_SLL, 32'd1, 32'd20, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_result", result, 32'd0);
        chk("async_rst_flags", {28'd0, zf, cf, vf, sf}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = dones;
        repeat (30) @(negedge clk);
        chk("rst_no_done", dones, d0);
        chk("rst_result_kept", result, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
